// File: rtl/tx_prbs31_generator.sv
// PRBS31 transmit word generator, 32 bits per cycle.
// Start/stop/enable control plus single-bit error injection.
module tx_prbs31_generator #(
  parameter logic [30:0] SEED   = 31'h7FFFFFFF,
  parameter int          WCNT_W = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              enable,
  input  logic              inject,
  input  logic [4:0]        inject_pos,
  output logic [31:0]       DataOut,
  output logic              DataValid,
  output logic [WCNT_W-1:0] Word_Count,
  output logic [15:0]       Inject_Count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_nx;
  logic [30:0] lfsr;
  logic        pend;
  logic [4:0]  pend_pos;
  logic [31:0] word_nx;
  logic [31:0] flip;
  logic        go;

  // e[62] is the oldest state bit; e[31:0] is the next word
  function automatic logic [31:0] prbs_word(input logic [30:0] s);
    logic [62:0] e;
    e = '0;
    e[62:32] = s;
    for (int i = 31; i >= 0; i--)
      e[i] = e[i+31] ^ e[i+28];
    return e[31:0];
  endfunction

  assign word_nx = prbs_word(lfsr);
  assign flip    = pend ? (32'd1 << pend_pos) : 32'd0;
  assign go      = (state == RUN) && !stop && enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !stop) state_nx = RUN;
      RUN:     if (stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr         <= SEED;
      DataOut      <= '0;
      DataValid    <= 1'b0;
      Word_Count   <= '0;
      Inject_Count <= '0;
      pend         <= 1'b0;
      pend_pos     <= '0;
    end else if (state == IDLE) begin
      lfsr      <= SEED;
      DataOut   <= '0;
      DataValid <= 1'b0;
      pend      <= 1'b0;
      if (start && !stop) begin
        Word_Count   <= '0;
        Inject_Count <= '0;
      end
    end else if (stop) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      pend      <= 1'b0;
    end else begin
      DataValid <= go;
      if (go) begin
        // state advances on the clean word; the flip is output-only
        lfsr       <= word_nx[30:0];
        DataOut    <= word_nx ^ flip;
        Word_Count <= Word_Count + 1'b1;
      end
      if (go && pend) begin
        pend <= 1'b0;
        if (Inject_Count != 16'hFFFF)
          Inject_Count <= Inject_Count + 16'd1;
      end else if (inject && !pend) begin
        pend     <= 1'b1;
        pend_pos <= inject_pos;
      end
    end
  end

endmodule

// File: tb/tb_tx_prbs31_generator.sv
// Directed bench for tx_prbs31_generator.
// Vector table plus long-run stream, inject and reset sequences.
module tb_tx_prbs31_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        enable = 1'b0;
  logic        inject = 1'b0;
  logic [4:0]  inject_pos = '0;
  logic [31:0] DataOut, DataOut2;
  logic        DataValid, DataValid2;
  logic [47:0] Word_Count;
  logic [2:0]  Word_Count2;
  logic [15:0] Inject_Count, Inject_Count2;

  int tests = 0;
  int fails = 0;

  tx_prbs31_generator dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .enable(enable), .inject(inject), .inject_pos(inject_pos),
    .DataOut(DataOut), .DataValid(DataValid),
    .Word_Count(Word_Count), .Inject_Count(Inject_Count)
  );

  tx_prbs31_generator #(.WCNT_W(3)) dut2 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .enable(enable), .inject(inject), .inject_pos(inject_pos),
    .DataOut(DataOut2), .DataValid(DataValid2),
    .Word_Count(Word_Count2), .Inject_Count(Inject_Count2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        sp;
    logic        en;
    logic        inj;
    logic [4:0]  pos;
    logic        dv;
    logic [31:0] d;
    int          wc;
    int          ic;
  } vec_t;

  vec_t v[14];
  bit   mq[$];
  bit   rx[$];
  int   errs;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic en,
                      input logic inj, input logic [4:0] pos);
    start = st;
    stop = sp;
    enable = en;
    inject = inj;
    inject_pos = pos;
    @(posedge clock);
    #1;
  endtask

  // bit-serial reference: s[n] = s[n-31] ^ s[n-28]
  task automatic model_init();
    mq.delete();
    for (int i = 0; i < 31; i++) mq.push_back(1'b1);
  endtask

  task automatic model_word(output logic [31:0] w);
    int n;
    bit b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      n = mq.size();
      b = mq[n-31] ^ mq[n-28];
      mq.push_back(b);
      w = {w[30:0], b};
    end
  endtask

  // receive-side checker: counts bits breaking the recurrence
  task automatic check_rx(input logic [31:0] w);
    int m;
    for (int i = 31; i >= 0; i--) begin
      rx.push_back(w[i]);
      m = rx.size() - 1;
      if (m >= 31 && rx[m] != (rx[m-31] ^ rx[m-28])) errs++;
    end
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] dmask;
    int ndiff, nlow, nw, errs_clean;

    v[0]  = '{0, 0, 0, 0, 5'd0, 0, 32'h0,        0, 0};
    v[1]  = '{1, 0, 1, 0, 5'd0, 0, 32'h0,        0, 0};
    v[2]  = '{0, 0, 1, 0, 5'd0, 1, 32'h0000000E, 1, 0};
    v[3]  = '{0, 0, 1, 0, 5'd0, 1, 32'h000000FC, 2, 0};
    v[4]  = '{0, 0, 0, 0, 5'd0, 0, 32'h000000FC, 2, 0};
    v[5]  = '{0, 0, 1, 0, 5'd0, 1, 32'h00000E38, 3, 0};
    v[6]  = '{0, 1, 1, 0, 5'd0, 0, 32'h0,        3, 0};
    v[7]  = '{1, 1, 1, 0, 5'd0, 0, 32'h0,        3, 0};
    v[8]  = '{0, 0, 1, 0, 5'd0, 0, 32'h0,        3, 0};
    v[9]  = '{1, 0, 1, 1, 5'd5, 0, 32'h0,        0, 0};
    v[10] = '{0, 0, 1, 0, 5'd0, 1, 32'h0000000E, 1, 0};
    v[11] = '{0, 0, 1, 1, 5'd0, 1, 32'h000000FC, 2, 0};
    v[12] = '{0, 0, 1, 0, 5'd0, 1, 32'h00000E39, 3, 1};
    v[13] = '{0, 1, 1, 0, 5'd0, 0, 32'h0,        3, 1};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_dv", 64'(DataValid), 64'd0);
    chk("rst_data", 64'(DataOut), 64'd0);
    chk("rst_wc", 64'(Word_Count), 64'd0);
    chk("rst_ic", 64'(Inject_Count), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(v[i].st, v[i].sp, v[i].en, v[i].inj, v[i].pos);
      chk($sformatf("v%0d_dv", i), 64'(DataValid), 64'(v[i].dv));
      chk($sformatf("v%0d_data", i), 64'(DataOut), 64'(v[i].d));
      chk($sformatf("v%0d_wc", i), 64'(Word_Count), 64'(v[i].wc));
      chk($sformatf("v%0d_ic", i), 64'(Inject_Count), 64'(v[i].ic));
    end

    // long run: 7-cycle pause and a back-to-back inject pair
    model_init();
    rx.delete();
    errs = 0;
    errs_clean = -1;
    ndiff = 0;
    nlow = 0;
    nw = 0;
    dmask = '0;
    step(1, 0, 1, 0, 5'd0);
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) errs_clean = errs;
      step(0, 0, !(c >= 300 && c < 307), (c == 500 || c == 501), 5'd5);
      if (DataValid) begin
        model_word(exp);
        if (DataOut !== exp) begin
          ndiff++;
          dmask = DataOut ^ exp;
        end
        check_rx(DataOut);
        nw++;
      end else begin
        nlow++;
      end
    end
    chk("run_clean_errs", 64'(errs_clean), 64'd0);
    chk("run_words", 64'(nw), 64'd993);
    chk("run_pause", 64'(nlow), 64'd7);
    chk("run_diff_words", 64'(ndiff), 64'd1);
    chk("run_diff_mask", 64'(dmask), 64'h20);
    chk("run_wc", 64'(Word_Count), 64'd993);
    chk("run_wc_wrap", 64'(Word_Count2), 64'd1);
    chk("run_ic", 64'(Inject_Count), 64'd1);
    chk("run_chk_errs", 64'(errs), 64'd3);

    // asynchronous reset mid-RUN
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", 64'(DataOut), 64'd0);
    chk("arst_dv", 64'(DataValid), 64'd0);
    chk("arst_wc", 64'(Word_Count), 64'd0);
    chk("arst_ic", 64'(Inject_Count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 1, 0, 5'd0);
    chk("post_idle_dv", 64'(DataValid), 64'd0);
    step(1, 0, 1, 0, 5'd0);
    step(0, 0, 1, 0, 5'd0);
    chk("post_first", 64'(DataOut), 64'h0000000E);
    chk("post_wc", 64'(Word_Count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
